// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the opcode encodings, the arbiter FSM state type and the result width.
package alu_pkg;

  localparam int RES_W = 16;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_NAND = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two command sources, the consumer
// and the ALU arbiter.
//   req_valid[1:0]  / req_ready[1:0]  : per-requester handshake
//   req_a0/b0/op0, req_a1/b1/op1      : per-requester operands and opcode
//   resp_valid / resp_ready           : response handshake
//   resp_id, resp_result, resp_carry, resp_zflag : response payload
// master: the requesters plus the response consumer. slave: the arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [7:0]       req_a0;
  logic [7:0]       req_b0;
  logic [2:0]       req_op0;
  logic [7:0]       req_a1;
  logic [7:0]       req_b1;
  logic [2:0]       req_op1;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [RES_W-1:0] resp_result;
  logic             resp_carry;
  logic             resp_zflag;

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_carry, resp_zflag
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_carry, resp_zflag
  );

endinterface

// File: rtl/ALU_8bit.sv
// Combinational 8-bit ALU with a 16-bit result.
//   a, b   : operands
//   op     : opcode (see alu_pkg)
//   result : 16-bit result (SUB wraps mod 2^16, MUL is the full product)
//   carry  : result[8] for ADD/SUB, 0 otherwise
//   zflag  : result == 0
module ALU_8bit
  import alu_pkg::*;
(
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [2:0]       op,
  output logic [RES_W-1:0] result,
  output logic             carry,
  output logic             zflag
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = {8'h00, a};
  assign b_ext = {8'h00, b};

  // Logic ops work on zero-extended operands, so the inverting ones
  // drive the upper byte to all ones.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a_ext + b_ext;
      ALU_SUB:  result = a_ext - b_ext;
      ALU_MUL:  result = a_ext * b_ext;
      ALU_AND:  result = a_ext & b_ext;
      ALU_OR:   result = a_ext | b_ext;
      ALU_NAND: result = ~(a_ext & b_ext);
      ALU_NOR:  result = ~(a_ext | b_ext);
      ALU_XOR:  result = a_ext ^ b_ext;
      default:  result = '0;
    endcase
  end

  assign carry = ((op == ALU_ADD) || (op == ALU_SUB)) ? result[8] : 1'b0;
  assign zflag = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU_8bit between two requesters. Round-robin picks one request,
// operands are latched and held for an execute window, then the ALU output
// is registered and offered on a valid/ready response channel.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/response bundle (slave side)
// Parameters: MUL_CYCLES / OP_CYCLES are the execute windows (>= 1).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int OP_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);

  localparam int MAX_WIN = (MUL_CYCLES > OP_CYCLES) ? MUL_CYCLES : OP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_WIN + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] OP_LOAD  = CNT_W'(OP_CYCLES - 1);

  alu_arb_state_t   state;
  logic             prio;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic [2:0]       op_q;
  logic             id_q;

  logic             gnt;
  logic             any_valid;
  logic [2:0]       op_sel;
  logic [RES_W-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zflag;

  // A lone requester always wins; on contention prio decides.
  always_comb begin
    any_valid = |bus.req_valid;
    case (bus.req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = prio;
      default: gnt = 1'b0;
    endcase
    op_sel        = gnt ? bus.req_op1 : bus.req_op0;
    bus.req_ready = 2'b00;
    if (!rst && (state == ST_IDLE) && any_valid) begin
      bus.req_ready[gnt] = 1'b1;
    end
  end

  ALU_8bit u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zflag  (alu_zflag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      prio            <= 1'b0;
      cnt             <= '0;
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= '0;
      id_q            <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_carry  <= 1'b0;
      bus.resp_zflag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // req_ready follows the grant, so any valid bit is a transfer here.
          if (any_valid) begin
            a_q   <= gnt ? bus.req_a1 : bus.req_a0;
            b_q   <= gnt ? bus.req_b1 : bus.req_b0;
            op_q  <= op_sel;
            id_q  <= gnt;
            cnt   <= (op_sel == ALU_MUL) ? MUL_LOAD : OP_LOAD;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            bus.resp_result <= alu_result;
            bus.resp_carry  <= alu_carry;
            bus.resp_zflag  <= alu_zflag;
            bus.resp_id     <= id_q;
            bus.resp_valid  <= 1'b1;
            state           <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            prio           <= ~id_q;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset values, single ADD, contention,
// MUL window, backpressure, SUB/NAND/NOR width rules and reset mid-EXEC.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_arbiter_if bus ();

  alu_arbiter #(.MUL_CYCLES(3), .OP_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [15:0] res, input logic cy,
                          input logic z, input logic id);
    chk({tag, "_valid"},  {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_result"}, {16'd0, bus.resp_result}, {16'd0, res});
    chk({tag, "_carry"},  {31'd0, bus.resp_carry}, {31'd0, cy});
    chk({tag, "_zflag"},  {31'd0, bus.resp_zflag}, {31'd0, z});
    chk({tag, "_id"},     {31'd0, bus.resp_id}, {31'd0, id});
  endtask

  task automatic set_r0(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
  endtask

  task automatic set_r1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 1'b0;
    set_r0(8'h00, 8'h00, ALU_ADD);
    set_r1(8'h00, 8'h00, ALU_ADD);
    #2;
    // Reset values, with both requesters already valid.
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_result", {16'd0, bus.resp_result}, 32'd0);
    chk("rst_resp_id", {31'd0, bus.resp_id}, 32'd0);
    chk("rst_resp_carry", {31'd0, bus.resp_carry}, 32'd0);
    chk("rst_resp_zflag", {31'd0, bus.resp_zflag}, 32'd0);
    cyc(); cyc();
    bus.req_valid = 2'b00;
    rst = 1'b0;
    #1;

    // Single ADD from requester 0: 200 + 100 = 300.
    set_r0(8'd200, 8'd100, ALU_ADD);
    bus.req_valid = 2'b01;
    #1 chk("add_ready", {30'd0, bus.req_ready}, 32'd1);
    cyc();
    bus.req_valid = 2'b00;
    #1;
    chk("add_exec_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("add_exec_ready", {30'd0, bus.req_ready}, 32'd0);
    cyc();
    chk_resp("add", 16'h012C, 1'b1, 1'b0, 1'b0);
    bus.resp_ready = 1'b1;
    cyc();
    chk("add_consumed", {31'd0, bus.resp_valid}, 32'd0);
    bus.resp_ready = 1'b0;

    // Contention straight out of reset.
    rst = 1'b1;
    bus.req_valid = 2'b11;
    set_r0(8'hF0, 8'h0F, ALU_AND);
    set_r1(8'hAA, 8'hAA, ALU_XOR);
    #1 chk("cont_rst_ready", {30'd0, bus.req_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    #1 chk("cont_first_grant", {30'd0, bus.req_ready}, 32'd1);
    cyc();
    chk("cont_exec_ready", {30'd0, bus.req_ready}, 32'd0);
    cyc();
    chk_resp("cont_r0", 16'h0000, 1'b0, 1'b1, 1'b0);
    bus.resp_ready = 1'b1;
    cyc();
    chk("cont_consumed", {31'd0, bus.resp_valid}, 32'd0);
    chk("cont_second_grant", {30'd0, bus.req_ready}, 32'd2);
    cyc(); cyc();
    chk_resp("cont_r1", 16'h0000, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("cont_third_grant", {30'd0, bus.req_ready}, 32'd1);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    chk_resp("cont_r0_again", 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("cont_end", {31'd0, bus.resp_valid}, 32'd0);
    bus.resp_ready = 1'b0;

    // MUL window from requester 1: 255 * 255, 3 cycles.
    set_r1(8'hFF, 8'hFF, ALU_MUL);
    bus.req_valid = 2'b10;
    #1 chk("mul_ready", {30'd0, bus.req_ready}, 32'd2);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    chk("mul_lat1", {31'd0, bus.resp_valid}, 32'd0);
    cyc();
    chk("mul_lat2", {31'd0, bus.resp_valid}, 32'd0);
    cyc();
    chk_resp("mul", 16'hFE01, 1'b0, 1'b0, 1'b1);

    // Backpressure: hold for 5 cycles with a pending request.
    set_r0(8'd3, 8'd5, ALU_SUB);
    bus.req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("bp_result", {16'd0, bus.resp_result}, 32'h0000FE01);
      chk("bp_id", {31'd0, bus.resp_id}, 32'd1);
      chk("bp_req_ready", {30'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    cyc();
    chk("bp_consumed", {31'd0, bus.resp_valid}, 32'd0);
    chk("bp_resume_ready", {30'd0, bus.req_ready}, 32'd1);

    // SUB with borrow: 3 - 5.
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    chk_resp("sub", 16'hFFFE, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("sub_consumed", {31'd0, bus.resp_valid}, 32'd0);

    // NAND from requester 1: ~(FF & 0F) zero-extended.
    set_r1(8'hFF, 8'h0F, ALU_NAND);
    bus.req_valid = 2'b10;
    #1 chk("nand_ready", {30'd0, bus.req_ready}, 32'd2);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    chk_resp("nand", 16'hFFF0, 1'b0, 1'b0, 1'b1);
    cyc();

    // NOR from requester 0: ~(0 | 0).
    set_r0(8'h00, 8'h00, ALU_NOR);
    bus.req_valid = 2'b01;
    #1 chk("nor_ready", {30'd0, bus.req_ready}, 32'd1);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    chk_resp("nor", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    cyc();

    // Reset mid-EXEC discards a MUL; prio (1 at this point) returns to 0.
    set_r1(8'd7, 8'd9, ALU_MUL);
    bus.req_valid = 2'b10;
    #1 chk("rexec_ready", {30'd0, bus.req_ready}, 32'd2);
    cyc();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("rexec_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rexec_req_ready", {30'd0, bus.req_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rexec_hold_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rexec_hold_result", {16'd0, bus.resp_result}, 32'd0);
    end
    set_r0(8'h00, 8'h00, ALU_ADD);
    set_r1(8'h12, 8'h34, ALU_OR);
    bus.req_valid = 2'b11;
    rst = 1'b0;
    #1 chk("rexec_prio_grant", {30'd0, bus.req_ready}, 32'd1);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    chk_resp("rexec_add", 16'h0000, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("rexec_consumed", {31'd0, bus.resp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
